// File: rtl/fsm_autotest_multi.sv
// Autotest sequencer: reads a config block from SD, runs the UUT N times with a
// cycle timer and timeout, then writes a result block with the config echo and
// one {time,status} record per iteration.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | leaving reset, start the SD init
// SPI_RST   | init request held until busy, then wait for busy low
// RD_BLK    | open read session on START_BLOCK, clear byte counter
// RD_BYTE   | byte read request held until busy
// RD_WAIT   | wait for busy low, capture spi_data_out
// CHECK     | validate signature, decide on runs
// UUT_RST   | UUT held in reset for UUT_RST_CYCLES cycles, timer cleared
// RUN       | UUT running, timer counting
// RECORD    | store {time,status} for this iteration
// WR_BLK    | open write session on START_BLOCK+1, preload first byte
// WR_BYTE   | byte write request held until busy
// WR_WAIT   | wait for busy low, advance to next byte
// DONE      | sequence complete, held until reset
// ERROR     | sequence aborted, held until reset
module fsm_autotest_multi #(
    parameter logic [31:0] START_BLOCK    = 32'h0010_0000,
    parameter int          PARAM_BYTES    = 8,
    parameter int          ITER_MAX       = 16,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'h06E0_0000,
    parameter logic [31:0] SIGNATURE      = 32'hAABB_CCDD,
    parameter int          UUT_RST_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     spi_busy,
    input  logic                     spi_err,
    input  logic                     spi_crc_err,
    input  logic [7:0]               spi_data_out,
    output logic [31:0]              spi_block_addr,
    output logic                     spi_rst,
    output logic                     spi_r_block,
    output logic                     spi_r_byte,
    output logic                     spi_w_block,
    output logic                     spi_w_byte,
    output logic [7:0]               spi_data_in,
    output logic                     uut_ctrl_mux,
    output logic                     uut_rst,
    output logic                     uut_start,
    input  logic                     uut_finish,
    output logic [8*PARAM_BYTES-1:0] uut_params,
    output logic                     done,
    output logic                     error,
    output logic [1:0]               err_code,
    output logic [31:0]              debug_signal
);

    if (5 + PARAM_BYTES + 5 * ITER_MAX > 512) begin : g_bad_cfg
        $error("fsm_autotest_multi: config echo plus records exceed one block");
    end

    localparam int IW = (ITER_MAX > 1) ? $clog2(ITER_MAX) : 1;
    localparam logic [9:0] REC_BASE = 10'(5 + PARAM_BYTES);

    typedef enum logic [4:0] {
        S_IDLE, S_SPI_RST, S_RD_BLK, S_RD_BYTE, S_RD_WAIT, S_CHECK, S_UUT_RST,
        S_RUN, S_RECORD, S_WR_BLK, S_WR_BYTE, S_WR_WAIT, S_DONE, S_ERROR
    } state_t;

    state_t                   state_q, state_d;
    logic                     ack_q;
    logic [9:0]               byte_cnt_q;
    logic [31:0]              sig_q;
    logic [7:0]               n_q;
    logic [8*PARAM_BYTES-1:0] params_q;
    logic [7:0]               iter_q;
    logic [31:0]              timer_q;
    logic [7:0]               rst_cnt_q;
    logic [31:0]              exit_time_q;
    logic [7:0]               exit_status_q;
    logic [31:0]              rec_time_q   [ITER_MAX];
    logic [7:0]               rec_status_q [ITER_MAX];
    logic [1:0]               err_code_q, err_code_d;
    logic [31:0]              addr_q;
    logic [7:0]               data_in_q;

    logic       rd_op, spi_op, timeout_hit;
    logic [9:0] wr_idx, rel, rec_i;
    logic [2:0] off;
    logic [7:0] wr_byte;

    assign rd_op  = (state_q == S_RD_BLK) || (state_q == S_RD_BYTE) || (state_q == S_RD_WAIT);
    assign spi_op = rd_op || (state_q == S_SPI_RST) || (state_q == S_WR_BLK) ||
                    (state_q == S_WR_BYTE) || (state_q == S_WR_WAIT);
    assign timeout_hit = (timer_q == TIMEOUT_CYCLES - 32'd1);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; SPI faults override whatever the state wanted to do
    always_comb begin
        state_d    = state_q;
        err_code_d = err_code_q;
        case (state_q)
            S_IDLE:    state_d = S_SPI_RST;
            S_SPI_RST: if (ack_q && !spi_busy) state_d = S_RD_BLK;
            S_RD_BLK:  state_d = S_RD_BYTE;
            S_RD_BYTE: if (spi_busy) state_d = S_RD_WAIT;
            S_RD_WAIT: if (!spi_busy) state_d = (byte_cnt_q == 10'd511) ? S_CHECK : S_RD_BYTE;
            S_CHECK: begin
                if (sig_q != SIGNATURE) begin
                    state_d    = S_ERROR;
                    err_code_d = 2'd1;
                end else if (n_q == 8'd0) begin
                    state_d = S_WR_BLK;
                end else begin
                    state_d = S_UUT_RST;
                end
            end
            S_UUT_RST: if (rst_cnt_q == 8'd0) state_d = S_RUN;
            S_RUN:     if (uut_finish || timeout_hit) state_d = S_RECORD;
            S_RECORD:  state_d = ((iter_q + 8'd1) < n_q) ? S_UUT_RST : S_WR_BLK;
            S_WR_BLK:  state_d = S_WR_BYTE;
            S_WR_BYTE: if (spi_busy) state_d = S_WR_WAIT;
            S_WR_WAIT: if (!spi_busy) state_d = (byte_cnt_q == 10'd511) ? S_DONE : S_WR_BYTE;
            default:   state_d = state_q;
        endcase
        if (rd_op && spi_crc_err) begin
            state_d    = S_ERROR;
            err_code_d = 2'd3;
        end else if (spi_op && spi_err) begin
            state_d    = S_ERROR;
            err_code_d = 2'd2;
        end
    end

    // Result block byte for the next write transfer
    always_comb begin
        wr_idx  = (state_q == S_WR_BLK) ? 10'd0 : byte_cnt_q + 10'd1;
        rel     = wr_idx - REC_BASE;
        rec_i   = rel / 10'd5;
        off     = 3'(rel % 10'd5);
        wr_byte = 8'h00;
        if (wr_idx < 10'd4) begin
            case (wr_idx[1:0])
                2'd0:    wr_byte = sig_q[31:24];
                2'd1:    wr_byte = sig_q[23:16];
                2'd2:    wr_byte = sig_q[15:8];
                default: wr_byte = sig_q[7:0];
            endcase
        end else if (wr_idx == 10'd4) begin
            wr_byte = n_q;
        end else if (wr_idx < REC_BASE) begin
            for (int k = 0; k < PARAM_BYTES; k++)
                if (wr_idx == 10'(5 + k)) wr_byte = params_q[8*k +: 8];
        end else if (rec_i < {2'b00, n_q}) begin
            case (off)
                3'd0:    wr_byte = rec_time_q[rec_i[IW-1:0]][7:0];
                3'd1:    wr_byte = rec_time_q[rec_i[IW-1:0]][15:8];
                3'd2:    wr_byte = rec_time_q[rec_i[IW-1:0]][23:16];
                3'd3:    wr_byte = rec_time_q[rec_i[IW-1:0]][31:24];
                default: wr_byte = rec_status_q[rec_i[IW-1:0]];
            endcase
        end
    end

    // Datapath: config capture, run timer, records, write byte register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q         <= 1'b0;
            byte_cnt_q    <= '0;
            sig_q         <= '0;
            n_q           <= '0;
            params_q      <= '0;
            iter_q        <= '0;
            timer_q       <= '0;
            rst_cnt_q     <= '0;
            exit_time_q   <= '0;
            exit_status_q <= '0;
            err_code_q    <= '0;
            addr_q        <= '0;
            data_in_q     <= '0;
            for (int i = 0; i < ITER_MAX; i++) begin
                rec_time_q[i]   <= '0;
                rec_status_q[i] <= '0;
            end
        end else begin
            ack_q      <= (state_q == S_SPI_RST) && (ack_q || spi_busy);
            err_code_q <= err_code_d;
            if (state_d == S_RD_BLK) addr_q <= START_BLOCK;
            if (state_d == S_WR_BLK) addr_q <= START_BLOCK + 32'd1;
            case (state_q)
                S_RD_BLK: byte_cnt_q <= '0;
                S_RD_WAIT: if (!spi_busy) begin
                    byte_cnt_q <= byte_cnt_q + 10'd1;
                    if (byte_cnt_q < 10'd4) sig_q <= {sig_q[23:0], spi_data_out};
                    if (byte_cnt_q == 10'd4)
                        n_q <= (spi_data_out > 8'(ITER_MAX)) ? 8'(ITER_MAX) : spi_data_out;
                    for (int k = 0; k < PARAM_BYTES; k++)
                        if (byte_cnt_q == 10'(5 + k)) params_q[8*k +: 8] <= spi_data_out;
                end
                S_CHECK: begin
                    iter_q    <= '0;
                    rst_cnt_q <= 8'(UUT_RST_CYCLES - 1);
                end
                S_UUT_RST: begin
                    timer_q <= '0;
                    if (rst_cnt_q != 8'd0) rst_cnt_q <= rst_cnt_q - 8'd1;
                end
                S_RUN: begin
                    timer_q <= timer_q + 32'd1;
                    if (uut_finish || timeout_hit) begin
                        exit_time_q   <= timer_q;
                        exit_status_q <= uut_finish ? 8'h01 : 8'h02;
                    end
                end
                S_RECORD: begin
                    rec_time_q[iter_q[IW-1:0]]   <= exit_time_q;
                    rec_status_q[iter_q[IW-1:0]] <= exit_status_q;
                    iter_q    <= iter_q + 8'd1;
                    rst_cnt_q <= 8'(UUT_RST_CYCLES - 1);
                end
                S_WR_BLK: begin
                    byte_cnt_q <= '0;
                    data_in_q  <= wr_byte;
                end
                S_WR_WAIT: if (!spi_busy) begin
                    byte_cnt_q <= byte_cnt_q + 10'd1;
                    data_in_q  <= wr_byte;
                end
                default: ;
            endcase
        end
    end

    assign spi_block_addr = addr_q;
    assign spi_rst        = (state_q == S_SPI_RST) && !ack_q;
    assign spi_r_block    = rd_op;
    assign spi_r_byte     = (state_q == S_RD_BYTE);
    assign spi_w_block    = (state_q == S_WR_BLK) || (state_q == S_WR_BYTE) || (state_q == S_WR_WAIT);
    assign spi_w_byte     = (state_q == S_WR_BYTE);
    assign spi_data_in    = data_in_q;
    assign uut_ctrl_mux   = (state_q == S_UUT_RST) || (state_q == S_RUN) || (state_q == S_RECORD);
    assign uut_rst        = !((state_q == S_RUN) || (state_q == S_RECORD));
    assign uut_start      = (state_q == S_RUN);
    assign uut_params     = params_q;
    assign done           = (state_q == S_DONE);
    assign error          = (state_q == S_ERROR);
    assign err_code       = err_code_q;
    assign debug_signal   = {iter_q, byte_cnt_q[9:2], 8'h00, 3'h0, state_q};

endmodule
